// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, reg bus structs, decoder regions and a byte-strobe merge helper.
package clint_pkg;
    localparam logic [15:0] MsipBase     = 16'h0000;
    localparam logic [15:0] MtimecmpBase = 16'h4000;
    localparam logic [15:0] MtimeLo      = 16'hBFF8;
    localparam logic [15:0] MtimeHi      = 16'hBFFC;
    localparam int unsigned MaxHarts     = 4095;

    typedef logic [63:0] mtime_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } clint_rsp_t;

    typedef enum logic [1:0] {
        RegNone,
        RegMsip,
        RegMtimecmp,
        RegMtime
    } reg_kind_e;

    function automatic logic [31:0] mergeStrobe(input logic [31:0] oldWord,
                                                input logic [31:0] newWord,
                                                input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction
endpackage

// File: rtl/clint_rtc_tick.sv
// RTC synchroniser, rising-edge detect and prescaler; tick_o pulses for one cycle every Prescale RTC rising edges.
module clint_rtc_tick #(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned Prescale   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rtc_i,
    output logic tick_o
);
    localparam int unsigned     CntW   = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Prescale - 1);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  rtcPrev_q, rtcPrev_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  rise;

    always_comb begin
        sync_d    = {sync_q[SyncStages-2:0], rtc_i};
        rtcPrev_d = sync_q[SyncStages-1];
        rise      = sync_q[SyncStages-1] & ~rtcPrev_q;
        count_d   = count_q;
        tick_o    = 1'b0;
        if (rise) begin
            if (count_q == CntMax) begin
                count_d = '0;
                tick_o  = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            rtcPrev_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            rtcPrev_q <= rtcPrev_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: rtl/clint_timer_multi.sv
// Parametrised CLINT: 64-bit mtime, per-hart mtimecmp/msip, registered timer IRQs, decoder with error responses.
// Optional macro CLINT_MTIME_SNAPSHOT_EN latches mtime[63:32] on a low-word read for race-free 32-bit reads.
module clint_timer_multi
    import clint_pkg::*;
#(
    parameter int unsigned NumHarts   = 10,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned Prescale   = 1,
    parameter type         reg_req_t  = clint_req_t,
    parameter type         reg_rsp_t  = clint_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  reg_req_t            reg_req_i,
    output reg_rsp_t            reg_rsp_o,
    input  logic                rtc_i,
    output logic [NumHarts-1:0] timer_irq_o,
    output logic [NumHarts-1:0] ipi_o
);
    logic [15:0]         wordAddr;
    logic [11:0]         hartIdx;
    logic                cmpHi, decErr, wrEn, tick;
    reg_kind_e           kind;
    logic [31:0]         rdata, mtimeHiRd;
    logic                selMsip;
    mtime_t              selCmp;
    mtime_t              mtime_q, mtime_d;
    mtime_t              mtimecmp_q [NumHarts];
    mtime_t              mtimecmp_d [NumHarts];
    logic [NumHarts-1:0] msip_q, msip_d, timerIrq_q, timerIrq_d;

    clint_rtc_tick #(
        .SyncStages (SyncStages),
        .Prescale   (Prescale)
    ) u_rtc_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rtc_i  (rtc_i),
        .tick_o (tick)
    );

    // mtimecmp slots are 8 bytes apart starting at an 8-aligned base, so address bit 2 picks the half
    always_comb begin
        wordAddr = reg_req_i.addr & 16'hFFFC;
        kind     = RegNone;
        hartIdx  = '0;
        cmpHi    = wordAddr[2];
        if (wordAddr < MtimecmpBase) begin
            kind    = RegMsip;
            hartIdx = wordAddr[13:2];
        end else if (wordAddr < MtimeLo) begin
            kind    = RegMtimecmp;
            hartIdx = 12'((wordAddr - MtimecmpBase) >> 3);
        end else if (wordAddr == MtimeLo || wordAddr == MtimeHi) begin
            kind = RegMtime;
        end
        decErr = (kind == RegNone) ||
                 ((kind == RegMsip || kind == RegMtimecmp) && (32'(hartIdx) >= NumHarts));
    end

    assign wrEn = reg_req_i.valid && reg_req_i.write && (|reg_req_i.wstrb) && !decErr;

    // A write to an mtime word wins over the tick for that word; the tick carry never crosses into the other word
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wrEn && kind == RegMtime) begin
            if (cmpHi) begin
                mtime_d = {mergeStrobe(mtime_q[63:32], reg_req_i.wdata, reg_req_i.wstrb), mtime_d[31:0]};
            end else begin
                mtime_d = {mtime_q[63:32], mergeStrobe(mtime_q[31:0], reg_req_i.wdata, reg_req_i.wstrb)};
            end
        end
        for (int i = 0; i < NumHarts; i++) begin
            if (wrEn && hartIdx == 12'(i)) begin
                if (kind == RegMsip && reg_req_i.wstrb[0]) msip_d[i] = reg_req_i.wdata[0];
                if (kind == RegMtimecmp) begin
                    if (cmpHi) begin
                        mtimecmp_d[i][63:32] = mergeStrobe(mtimecmp_q[i][63:32], reg_req_i.wdata, reg_req_i.wstrb);
                    end else begin
                        mtimecmp_d[i][31:0] = mergeStrobe(mtimecmp_q[i][31:0], reg_req_i.wdata, reg_req_i.wstrb);
                    end
                end
            end
            timerIrq_d[i] = (mtime_q >= mtimecmp_q[i]);
        end
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic        rdEn;
    logic [31:0] shadow_q, shadow_d;

    assign rdEn = reg_req_i.valid && !reg_req_i.write && !decErr;

    always_comb begin
        shadow_d = shadow_q;
        if (rdEn && kind == RegMtime && !cmpHi) shadow_d = mtime_q[63:32];
        if (wrEn && kind == RegMtime && cmpHi) begin
            shadow_d = mergeStrobe(mtime_q[63:32], reg_req_i.wdata, reg_req_i.wstrb);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end

    assign mtimeHiRd = shadow_q;
`else
    assign mtimeHiRd = mtime_q[63:32];
`endif

    always_comb begin
        selMsip = 1'b0;
        selCmp  = '0;
        for (int i = 0; i < NumHarts; i++) begin
            if (hartIdx == 12'(i)) begin
                selMsip = msip_q[i];
                selCmp  = mtimecmp_q[i];
            end
        end
        case (kind)
            RegMsip:     rdata = {31'd0, selMsip};
            RegMtimecmp: rdata = cmpHi ? selCmp[63:32] : selCmp[31:0];
            RegMtime:    rdata = cmpHi ? mtimeHiRd : mtime_q[31:0];
            default:     rdata = '0;
        endcase
        if (decErr) rdata = '0;
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = reg_req_i.valid && decErr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            msip_q     <= '0;
            timerIrq_q <= '0;
            for (int i = 0; i < NumHarts; i++) mtimecmp_q[i] <= '1;
        end else begin
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            timerIrq_q <= timerIrq_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign timer_irq_o = timerIrq_q;
    assign ipi_o       = msip_q;
endmodule
